// File: rtl/sspi_pkg.sv
// Shared opcodes, FSM state encoding and per-opcode payload lengths for the MCU SPI command port.
package sspi_pkg;

  localparam logic [7:0] OP_READ    = 8'd0;
  localparam logic [7:0] OP_GETCFG  = 8'd1;
  localparam logic [7:0] OP_SETCFG  = 8'd2;
  localparam logic [7:0] OP_OVERLAY = 8'd3;
  localparam logic [7:0] OP_RSVD4   = 8'd4;
  localparam logic [7:0] OP_ROM     = 8'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPC  = 3'd1,
    PAY  = 3'd2,
    LEN  = 3'd3,
    ROM  = 3'd4,
    SKIP = 3'd5
  } state_e;

  // Bytes following the opcode; for OP_ROM this is the length field only.
  function automatic logic [2:0] pay_len(input logic [7:0] op);
    case (op)
      OP_READ:    pay_len = 3'd0;
      OP_SETCFG:  pay_len = 3'd4;
      OP_RSVD4:   pay_len = 3'd2;
      OP_ROM:     pay_len = 3'd3;
      default:    pay_len = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/sspi_shift.sv
// SPI mode-0 slave front end: 2-flop synchronisers, edge detect, rx/tx shift registers in the clk domain.
module sspi_shift (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       sspi_cs_i,
  input  logic       sspi_clk_i,
  input  logic       sspi_mosi_i,
  input  logic [7:0] tx_byte_i,
  output logic       sspi_miso_o,
  output logic       cs_fall_o,
  output logic       cs_rise_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o
);

  logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic       cs_prev_q, sclk_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic [7:0] rx_byte_q, tx_sr_q;
  logic       rx_valid_q, reload_q;
  logic       cs_low, sclk_rise;

  // CS chain resets to "low" so a reset inside a frame never fakes a CS fall.
  assign cs_low    = ~cs_sync_q[1];
  assign cs_fall_o = cs_prev_q & ~cs_sync_q[1];
  assign cs_rise_o = ~cs_prev_q & cs_sync_q[1];
  assign sclk_rise = cs_low & sclk_sync_q[1] & ~sclk_prev_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cs_sync_q   <= 2'b00;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_sr_q     <= 8'd0;
      reload_q    <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], sspi_cs_i};
      sclk_sync_q <= {sclk_sync_q[0], sspi_clk_i};
      mosi_sync_q <= {mosi_sync_q[0], sspi_mosi_i};
      cs_prev_q   <= cs_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
      rx_valid_q  <= 1'b0;
      reload_q    <= rx_valid_q;
      if (!cs_low) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise) begin
        rx_sr_q   <= {rx_sr_q[5:0], mosi_sync_q[1]};
        tx_sr_q   <= {tx_sr_q[6:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_q  <= {rx_sr_q, mosi_sync_q[1]};
          rx_valid_q <= 1'b1;
        end
      end
      // Reload one cycle after rx_valid so a pointer update from this byte is visible.
      if (cs_fall_o || reload_q) tx_sr_q <= tx_byte_i;
    end
  end

  assign sspi_miso_o = tx_sr_q[7];
  assign rx_valid_o  = rx_valid_q;
  assign rx_byte_o   = rx_byte_q;

endmodule

// File: rtl/sspi_ctrl.sv
// Command FSM behind the MCU SPI port: config string readback, core_config/overlay writes, ROM download.
// ROM download (opcode 7) is built only when SSPI_ROM_LOAD_EN is defined; otherwise opcode 7 is skipped.
//
// state | meaning
// IDLE  | CS high, waiting for CS fall
// OPC   | waiting for opcode byte
// PAY   | consuming fixed-length payload (pcnt_q bytes left)
// LEN   | collecting 3-byte big-endian ROM length
// ROM   | streaming ROM bytes, cnt_q bytes left
// SKIP  | ignoring bytes until CS rise
module sspi_ctrl
  import sspi_pkg::*;
#(
  parameter int                    CONF_LEN = 5,
  parameter logic [8*CONF_LEN-1:0] CONF_STR = "core;"
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        sspi_cs_i,
  input  logic        sspi_clk_i,
  input  logic        sspi_mosi_i,
  output logic        sspi_miso_o,
  output logic [31:0] core_config_o,
  output logic        overlay_o,
  output logic        rom_loading_o,
  output logic [7:0]  rom_do_o,
  output logic        rom_do_valid_o
);

  localparam logic [7:0] LEN8 = 8'(CONF_LEN);

  logic        cs_fall, cs_rise, rx_valid;
  logic [7:0]  rx_byte, tx_byte;
  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d, op_q, op_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [23:0] hold_q, hold_d;
  logic [31:0] cfg_q, cfg_d;
  logic        ovl_q, ovl_d;
`ifdef SSPI_ROM_LOAD_EN
  logic [23:0] cnt_q, cnt_d;
  logic        load_q, load_d;
  logic [7:0]  rdo_q, rdo_d;
  logic        rvalid_q, rvalid_d;
`endif

  sspi_shift u_shift (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .sspi_cs_i   (sspi_cs_i),
    .sspi_clk_i  (sspi_clk_i),
    .sspi_mosi_i (sspi_mosi_i),
    .tx_byte_i   (tx_byte),
    .sspi_miso_o (sspi_miso_o),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .rx_valid_o  (rx_valid),
    .rx_byte_o   (rx_byte)
  );

  // CONF_STR holds the first character in its most significant byte.
  always_comb begin
    tx_byte = 8'h00;
    if (ptr_q < LEN8) tx_byte = CONF_STR[8*(CONF_LEN-1-int'(ptr_q)) +: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    pcnt_d  = pcnt_q;
    hold_d  = hold_q;
    cfg_d   = cfg_q;
    ovl_d   = ovl_q;
`ifdef SSPI_ROM_LOAD_EN
    cnt_d    = cnt_q;
    load_d   = load_q;
    rdo_d    = rdo_q;
    rvalid_d = 1'b0;
`endif
    case (state_q)
      OPC: if (rx_valid) begin
        op_d   = rx_byte;
        pcnt_d = pay_len(rx_byte);
        case (rx_byte)
          OP_READ: begin
            if (ptr_q < LEN8) ptr_d = ptr_q + 8'd1;
            state_d = SKIP;
          end
          OP_ROM: begin
`ifdef SSPI_ROM_LOAD_EN
            state_d = LEN;
`else
            state_d = SKIP;
`endif
          end
          default: begin
            if (rx_byte == OP_GETCFG) ptr_d = 8'd0;
            state_d = PAY;
          end
        endcase
      end
      PAY: if (rx_valid) begin
        if (op_q == OP_SETCFG) begin
          hold_d = {hold_q[15:0], rx_byte};
          if (pcnt_q == 3'd1) cfg_d = {hold_q, rx_byte};
        end
        if (op_q == OP_OVERLAY) ovl_d = rx_byte[0];
        pcnt_d = pcnt_q - 3'd1;
        if (pcnt_q == 3'd1) state_d = SKIP;
      end
`ifdef SSPI_ROM_LOAD_EN
      LEN: if (rx_valid) begin
        cnt_d  = {cnt_q[15:0], rx_byte};
        pcnt_d = pcnt_q - 3'd1;
        if (pcnt_q == 3'd1) begin
          if ({cnt_q[15:0], rx_byte} == 24'd0) begin
            state_d = SKIP;
          end else begin
            load_d  = 1'b1;
            state_d = ROM;
          end
        end
      end
      ROM: if (rx_valid) begin
        rdo_d    = rx_byte;
        rvalid_d = 1'b1;
        cnt_d    = cnt_q - 24'd1;
        if (cnt_q == 24'd1) begin
          load_d  = 1'b0;
          state_d = SKIP;
        end
      end
`endif
      default: ;
    endcase
    if (cs_rise) begin
      state_d = IDLE;
`ifdef SSPI_ROM_LOAD_EN
      load_d  = 1'b0;
`endif
    end else if (cs_fall) begin
      state_d = OPC;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      ptr_q   <= LEN8;
      op_q    <= 8'd0;
      pcnt_q  <= 3'd0;
      hold_q  <= 24'd0;
      cfg_q   <= 32'd0;
      ovl_q   <= 1'b0;
`ifdef SSPI_ROM_LOAD_EN
      cnt_q    <= 24'd0;
      load_q   <= 1'b0;
      rdo_q    <= 8'd0;
      rvalid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      pcnt_q  <= pcnt_d;
      hold_q  <= hold_d;
      cfg_q   <= cfg_d;
      ovl_q   <= ovl_d;
`ifdef SSPI_ROM_LOAD_EN
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      rdo_q    <= rdo_d;
      rvalid_q <= rvalid_d;
`endif
    end
  end

  assign core_config_o = cfg_q;
  assign overlay_o     = ovl_q;
`ifdef SSPI_ROM_LOAD_EN
  assign rom_loading_o  = load_q;
  assign rom_do_o       = rdo_q;
  assign rom_do_valid_o = rvalid_q;
`else
  assign rom_loading_o  = 1'b0;
  assign rom_do_o       = 8'd0;
  assign rom_do_valid_o = 1'b0;
`endif

endmodule

// File: doc/sspi_ctrl.md
# sspi_ctrl

Command controller behind the MCU-facing SPI slave port of `sys`. It oversamples the SPI pins in the core clock domain and decodes framed commands from the MCU. It sequences the resulting actions: streaming the core config string back, latching `core_config`, setting the overlay flag, and driving ROM download bytes into the core. It is the only block that writes `core_config`, `overlay` and the `rom_*` outputs.

## Interface
Parameters:
- `CONF_STR`, `"core;"`: ASCII config string returned by cmd 1, sent first char first, with a 0 terminator appended.
- `CONF_LEN`, 5: number of characters in `CONF_STR`, 1..255.

Ports:
- `clk`  in  1  core clock, ≥4× `sspi_clk`.
- `resetn`  in  1  asynchronous active-low reset.
- `sspi_cs`  in  1  chip select, active low, asynchronous to `clk`.
- `sspi_clk`  in  1  SPI clock, mode 0, asynchronous to `clk`.
- `sspi_mosi`  in  1  MCU→FPGA data, MSB first.
- `sspi_miso`  out  1  FPGA→MCU data, MSB first.
- `core_config`  out  32  config word written by cmd 2.
- `overlay`  out  1  overlay enable written by cmd 3.
- `rom_loading`  out  1  high while a cmd 7 payload is being received.
- `rom_do`  out  8  ROM byte.
- `rom_do_valid`  out  1  one-`clk` strobe qualifying `rom_do`.

## Operation
- **Sub-module `sspi_shift`**
  - Synchronises `sspi_cs`, `sspi_clk` and `sspi_mosi` with 2 flops each and edge-detects them.
  - Samples MOSI on a detected SCLK rise.
  - Emits `rx_valid` (1 cycle) and `rx_byte` after the 8th rise.
  - Loads the tx byte on a CS fall and after each completed byte.
  - Shifts MISO on each SCLK rise, so the master samples it before the next rise.
  - CS high clears the bit counter.
- **Frame:** CS low … CS high. Byte 0 is the opcode; payload bytes follow.
- **CS rise returns the FSM to `IDLE` unconditionally.** Any partial payload is discarded: no `core_config` update, and `rom_loading` drops.
- **FSM states:** `IDLE`, `OPC`, `PAY`, `LEN`, `ROM`, `SKIP`.
  - `IDLE` → `OPC` on CS fall.
  - `OPC` → next state on `rx_valid`, by opcode:
    - 0 READ: advance the string pointer; stay in `SKIP`.
    - 1 GETCFG: pointer := 0; `PAY` with 1 byte, ignored.
    - 2 SETCFG: `PAY` with 4 bytes.
    - 3 OVERLAY: `PAY` with 1 byte; `overlay := bit0`.
    - 4 reserved: `PAY` with 2 bytes, discarded.
    - 7 ROM: `LEN`.
    - Other opcodes: `PAY` with 1 byte, discarded.
  - `LEN`: collects a 3-byte big-endian length `N`.
    - `N = 0` → `SKIP`.
    - Otherwise `rom_loading := 1` and go to `ROM`.
  - `ROM`: each `rx_valid` sets `rom_do := rx_byte`, strobes `rom_do_valid` and decrements a 24-bit counter. After the byte that makes it 0, `rom_loading := 0` and go to `SKIP`.
  - `SKIP`: ignores bytes until CS rise.
- **SETCFG:** payload shifts into a 32-bit holding register MSB first. `core_config` is written only after the 4th payload byte.
- **Tx byte:** `CONF_STR[ptr]` when `ptr < CONF_LEN`, else `8'h00`.
  - The pointer saturates at `CONF_LEN`.
  - The pointer advances only on a completed opcode-0 byte.
  - The tx byte is loaded at CS fall.
- **Reset values:** `sspi_miso` 0, `core_config` 0, `overlay` 0, `rom_loading` 0, `rom_do` 0, `rom_do_valid` 0, pointer `CONF_LEN` (reads return 0 until cmd 1), FSM `IDLE`.
- **Reset during a frame:** everything returns to reset values immediately. The remainder of the frame is ignored until the next CS fall.

## Timing
- CS-fall detect → MISO bit 7 valid: ≤3 `clk`. The master waits ≥100 ns after CS low.
- SCLK rise → next MISO bit: ≤3 `clk`.
- 8th SCLK rise → `rx_valid`: 3 `clk`.
- `rom_do_valid` / `core_config` / `overlay` update: 1 `clk` after `rx_valid`.
- `rom_loading` rises 1 `clk` after the 3rd length byte. It falls in the same cycle as the last `rom_do_valid`.
- CS rise → FSM in `IDLE`: ≤3 `clk`.
- SCLK high and low phases must each be ≥2 `clk`.

## Configuration
- **`SSPI_ROM_LOAD_EN` defined:** cmd 7 operates as described above.
- **`SSPI_ROM_LOAD_EN` undefined:**
  - Opcode 7 goes straight to `SKIP`.
  - `rom_loading`, `rom_do_valid` and `rom_do` are tied to 0.
  - The 24-bit counter is not built.

## Structure
- **Package `sspi_pkg`:** opcode constants (`OP_READ=0`, `OP_GETCFG=1`, `OP_SETCFG=2`, `OP_OVERLAY=3`, `OP_RSVD4=4`, `OP_ROM=7`), the FSM state encoding, and the payload length per opcode.
- **Sub-module `sspi_shift`:** synchroniser, edge detect, rx/tx shift registers. `sspi_ctrl` holds the FSM, pointer and registers.

## Test plan
- **Config string:** `CONF_STR="ab;"`, `CONF_LEN=3`. Frame {01,00}, then five 1-byte frames of 00 → MISO reads 61, 62, 3B, 00, 00.
- **SETCFG:** frame {02,A5,A5,A5,A5} → `core_config` = A5A5A5A5 within 4 `clk` of the last byte. The bench checks `core_config` still holds 0 before the 4th payload byte.
- **Aborted SETCFG:** frame {02,12,34} followed by CS high → `core_config` unchanged. The next frame {03,01} sets `overlay` = 1.
- **ROM load:** frame {07,00,00,03,11,22,33} → three `rom_do_valid` strobes carrying 11, 22, 33. `rom_loading` is high from after byte 3 until the 33 strobe. With `SSPI_ROM_LOAD_EN` undefined → no strobes.
- **Edge cases:**
  - ROM length 0 → `rom_loading` is never asserted.
  - CS rise after 1 of 3 ROM data bytes → `rom_loading` drops within 3 `clk`.
  - `resetn` pulse mid-frame → all outputs return to their reset values.
